// File: rtl/rom_arb_pkg.sv
// Shared widths, master identifiers and the round-robin pick used by the
// instruction-ROM port arbiter.
package rom_arb_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_e;

   // On a tie, the master that did not take the most recent grant wins.
   function automatic master_e rr_pick(input logic elig0, input logic elig1,
                                       input master_e last);
      if (elig0 && elig1) begin
         return (last == M1) ? M0 : M1;
      end
      return elig0 ? M0 : M1;
   endfunction

endpackage : rom_arb_pkg

// File: rtl/rom_resp_slot.sv
// One-entry response slot for a single ROM master: forwards the ROM word on
// the cycle after issue and parks it if the master is not ready.
module rom_resp_slot #(
   parameter int DATA_W = rom_arb_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              rready,
   output logic              infl,
   output logic              held,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [1:0] ST_EMPTY    = 2'd0;
   localparam logic [1:0] ST_INFLIGHT = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [DATA_W-1:0] slot_q;
   logic              capture;

   always_comb begin
      // NOTE: state_d takes its hold value first, so no path through the case leaves it unassigned and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (issue) state_d = ST_INFLIGHT;
         end
         ST_INFLIGHT: begin
            // A re-issue is only ever granted while this word is being consumed.
            if (issue)       state_d = ST_INFLIGHT;
            else if (rready) state_d = ST_EMPTY;
            else             state_d = ST_HELD;
         end
         ST_HELD: begin
            if (rready) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   assign capture = (state_q == ST_INFLIGHT) && !rready;

   // NOTE: the data slot has no reset; it is only observable while state_q is HELD, which reset clears.
   always_ff @(posedge clk) begin
      if (capture) slot_q <= rom_data;
   end

   assign infl   = (state_q == ST_INFLIGHT);
   assign held   = (state_q == ST_HELD);
   assign rvalid = infl | held;

   always_comb begin
      rdata = '0;
      if (infl)      rdata = rom_data;
      else if (held) rdata = slot_q;
   end

endmodule : rom_resp_slot

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing the synchronous-read instruction ROM between the
// fetch port (M0) and the debug/data-load port (M1).
module rom_port_arbiter #(
   parameter int ADDR_W = rom_arb_pkg::ADDR_W,
   parameter int DATA_W = rom_arb_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [DATA_W-1:0] m1_rdata,

   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   import rom_arb_pkg::*;

   logic    m0_infl, m0_held;
   logic    m1_infl, m1_held;
   logic    m0_elig, m1_elig;
   logic    any_gnt;
   master_e winner;
   master_e last_q;

   // A master may issue again while its previous word is being consumed.
   assign m0_elig = m0_req & ~m0_held & (~m0_infl | m0_rready);
   assign m1_elig = m1_req & ~m1_held & (~m1_infl | m1_rready);

   // Grants are combinational, so they are masked while reset is held.
   assign any_gnt = ~rst & (m0_elig | m1_elig);
   assign winner  = rr_pick(m0_elig, m1_elig, last_q);

   assign m0_gnt = any_gnt & (winner == M0);
   assign m1_gnt = any_gnt & (winner == M1);

   always_comb begin
      rom_addr = '0;
      if (m0_gnt)      rom_addr = m0_addr;
      else if (m1_gnt) rom_addr = m1_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          last_q <= M1;
      else if (any_gnt) last_q <= winner;
   end

   rom_resp_slot #(.DATA_W(DATA_W)) u_m0_slot (
      .clk      (clk),
      .rst      (rst),
      .issue    (m0_gnt),
      .rom_data (rom_data),
      .rready   (m0_rready),
      .infl     (m0_infl),
      .held     (m0_held),
      .rvalid   (m0_rvalid),
      .rdata    (m0_rdata)
   );

   rom_resp_slot #(.DATA_W(DATA_W)) u_m1_slot (
      .clk      (clk),
      .rst      (rst),
      .issue    (m1_gnt),
      .rom_data (rom_data),
      .rready   (m1_rready),
      .infl     (m1_infl),
      .held     (m1_held),
      .rvalid   (m1_rvalid),
      .rdata    (m1_rdata)
   );

endmodule : rom_port_arbiter

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter; the ROM model returns A000_0000 | addr
// one cycle after the address is presented.
module tb_rom_port_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m1_req;
   logic [13:0] m0_addr, m1_addr;
   logic        m0_gnt, m1_gnt;
   logic        m0_rvalid, m1_rvalid;
   logic        m0_rready, m1_rready;
   logic [31:0] m0_rdata, m1_rdata;
   logic [13:0] rom_addr;
   logic [31:0] rom_data;

   int total = 0;
   int bad   = 0;

   rom_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rready (m0_rready),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rready (m1_rready),
      .m1_rdata  (m1_rdata),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      rom_data <= 32'hA000_0000 | {18'b0, rom_addr};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_all(input string tag,
                             input logic g0, input logic g1, input logic [13:0] a,
                             input logic v0, input logic [31:0] d0,
                             input logic v1, input logic [31:0] d1);
      check({tag, ".m0_gnt"},    32'(m0_gnt),    32'(g0));
      check({tag, ".m1_gnt"},    32'(m1_gnt),    32'(g1));
      check({tag, ".rom_addr"},  32'(rom_addr),  32'(a));
      check({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'(v0));
      check({tag, ".m0_rdata"},  m0_rdata,       d0);
      check({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'(v1));
      check({tag, ".m1_rdata"},  m1_rdata,       d1);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      m0_req    = 1'b1;
      m0_addr   = 14'h0004;
      m1_req    = 1'b1;
      m1_addr   = 14'h0200;
      m0_rready = 1'b1;
      m1_rready = 1'b1;

      // Scenario 1: reset held with both requesting, then release.
      tick(); #1;
      expect_all("rst_hold", 0, 0, 14'h0, 0, 32'h0, 0, 32'h0);
      tick(); rst = 1'b0; #1;
      expect_all("rst_rel", 1, 0, 14'h0004, 0, 32'h0, 0, 32'h0);
      tick(); m0_req = 1'b0; m1_req = 1'b0; #1;
      expect_all("first_resp", 0, 0, 14'h0, 1, 32'hA000_0004, 0, 32'h0);

      // Scenario 2: M0 alone streams four addresses.
      for (int i = 0; i < 4; i++) begin
         tick(); m0_req = 1'b1; m0_addr = 14'(4 * i); #1;
         expect_all($sformatf("stream%0d", i), 1, 0, 14'(4 * i),
                    (i > 0), (i > 0) ? (32'hA000_0000 | 32'(4 * (i - 1))) : 32'h0,
                    0, 32'h0);
      end
      tick(); m0_req = 1'b0; #1;
      expect_all("stream_tail", 0, 0, 14'h0, 1, 32'hA000_000C, 0, 32'h0);

      // Scenario 3: contention; M0 won last, so M1 takes the first tie.
      for (int i = 0; i < 4; i++) begin
         tick(); m0_req = 1'b1; m0_addr = 14'h0010; m1_req = 1'b1; m1_addr = 14'h0020; #1;
         expect_all($sformatf("rr%0d", i), (i % 2 == 1), (i % 2 == 0),
                    (i % 2 == 0) ? 14'h0020 : 14'h0010,
                    (i == 2), (i == 2) ? 32'hA000_0010 : 32'h0,
                    (i % 2 == 1), (i % 2 == 1) ? 32'hA000_0020 : 32'h0);
      end
      tick(); m0_req = 1'b0; m1_req = 1'b0; #1;
      expect_all("rr_tail", 0, 0, 14'h0, 1, 32'hA000_0010, 0, 32'h0);

      // Scenario 4: M1 stalls its response for three cycles.
      tick(); m1_req = 1'b1; m1_addr = 14'h0100; m1_rready = 1'b0; #1;
      expect_all("stall_gnt", 0, 1, 14'h0100, 0, 32'h0, 0, 32'h0);
      tick(); m0_req = 1'b1; m0_addr = 14'h0030; m1_addr = 14'h0104; #1;
      expect_all("stall0", 1, 0, 14'h0030, 0, 32'h0, 1, 32'hA000_0100);
      tick(); #1;
      expect_all("stall1", 1, 0, 14'h0030, 1, 32'hA000_0030, 1, 32'hA000_0100);
      tick(); #1;
      expect_all("stall2", 1, 0, 14'h0030, 1, 32'hA000_0030, 1, 32'hA000_0100);
      tick(); m1_rready = 1'b1; #1;
      expect_all("held_consume", 1, 0, 14'h0030, 1, 32'hA000_0030, 1, 32'hA000_0100);
      tick(); #1;
      expect_all("held_regrant", 0, 1, 14'h0104, 1, 32'hA000_0030, 0, 32'h0);
      tick(); m0_req = 1'b0; m1_req = 1'b0; #1;
      expect_all("regrant_resp", 0, 0, 14'h0, 0, 32'h0, 1, 32'hA000_0104);

      // Scenario 5: reset pulse right after a grant discards the word.
      tick(); m0_req = 1'b1; m0_addr = 14'h0040; #1;
      expect_all("pre_rst_gnt", 1, 0, 14'h0040, 0, 32'h0, 0, 32'h0);
      tick(); rst = 1'b1; m0_req = 1'b0; #1;
      expect_all("mid_rst", 0, 0, 14'h0, 0, 32'h0, 0, 32'h0);
      tick(); rst = 1'b0; #1;
      expect_all("post_rst", 0, 0, 14'h0, 0, 32'h0, 0, 32'h0);
      tick(); m0_req = 1'b1; m0_addr = 14'h0004; m1_req = 1'b1; m1_addr = 14'h0200; #1;
      expect_all("post_rst_gnt", 1, 0, 14'h0004, 0, 32'h0, 0, 32'h0);
      tick(); m0_req = 1'b0; m1_req = 1'b0; #1;
      expect_all("post_rst_resp", 0, 0, 14'h0, 1, 32'hA000_0004, 0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rom_port_arbiter
